wb_mem_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter that shares the single main-RAM slave port between the CPU instruction master, the CPU data master and the debug master.
- Sits between the masters' m2s/s2m signal groups and the RAM slave port.
- Holds a grant for the whole bus cycle, including incrementing bursts.
- A watchdog aborts cycles the slave never answers, so a hung slave cannot lock out the debug master.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_rr_pick.sv | 31 +++
 rtl/wb_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone main-RAM arbiter.
// Holds the arbiter FSM state encoding and the Wishbone B3 cycle-type codes.
package wb_arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUS   = 2'd1;
    localparam logic [1:0] ABORT = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    // Wishbone B3 cycle type identifiers
    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_req  - request vector, one bit per master
//   i_last - index of the previous winner; scanning starts at i_last+1
//   o_gnt  - one-hot winner, all zero when nothing is requested
module wb_rr_pick #(
    parameter int NM = 3,
    parameter int LW = 2
) (
    input  logic [NM-1:0] i_req,
    input  logic [LW-1:0] i_last,
    output logic [NM-1:0] o_gnt
);

    logic [LW-1:0] w_idx;

    // Scan from lowest to highest priority so the last hit (closest to
    // i_last+1) overrides any earlier one.
    always_comb begin
        o_gnt = '0;
        w_idx = '0;
        for (int k = NM; k >= 1; k--) begin
            w_idx = LW'((int'(i_last) + k) % NM);
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing the main-RAM slave port between
// the instruction (0), data (1) and debug (2) masters. A grant is held for
// the whole bus cycle; a watchdog aborts cycles the slave never answers.
// Ports:
//   wb_clk_i / wb_rst_i      - clock, synchronous active-high reset
//   wbm_*_i                  - packed master requests, master i at [i*W +: W]
//   wbm_dat_o                - slave read data broadcast to all masters
//   wbm_ack/err/rty_o        - per-master responses (granted master only)
//   wbs_*_o / wbs_*_i        - RAM slave port
//   grant_o                  - registered one-hot grant, zero when idle
//   timeout_o                - one-cycle pulse while an abort is signalled
//
//   state | meaning
//   IDLE  | no owner; pick next requester after last winner
//   BUS   | granted master drives the slave port
//   ABORT | watchdog fired; err to owner, slave cycle dropped
//   DRAIN | wait for owner to release cyc, slave port silent
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM      = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NM*AW-1:0]     wbm_adr_i,
    input  logic [NM*DW-1:0]     wbm_dat_i,
    input  logic [NM*DW/8-1:0]   wbm_sel_i,
    input  logic [NM-1:0]        wbm_we_i,
    input  logic [NM-1:0]        wbm_cyc_i,
    input  logic [NM-1:0]        wbm_stb_i,
    input  logic [NM*3-1:0]      wbm_cti_i,
    input  logic [NM*2-1:0]      wbm_bte_i,
    output logic [DW-1:0]        wbm_dat_o,
    output logic [NM-1:0]        wbm_ack_o,
    output logic [NM-1:0]        wbm_err_o,
    output logic [NM-1:0]        wbm_rty_o,
    output logic [AW-1:0]        wbs_adr_o,
    output logic [DW-1:0]        wbs_dat_o,
    output logic [DW/8-1:0]      wbs_sel_o,
    output logic                 wbs_we_o,
    output logic                 wbs_cyc_o,
    output logic                 wbs_stb_o,
    output logic [2:0]           wbs_cti_o,
    output logic [1:0]           wbs_bte_o,
    input  logic [DW-1:0]        wbs_dat_i,
    input  logic                 wbs_ack_i,
    input  logic                 wbs_err_i,
    input  logic                 wbs_rty_i,
    output logic [NM-1:0]        grant_o,
    output logic                 timeout_o
);

    localparam int          LW         = (NM > 1) ? $clog2(NM) : 1;
    localparam int          SW         = DW / 8;
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [NM-1:0] r_grant;
    logic [LW-1:0] r_last;
    logic [15:0]   r_wdog;
    logic          r_timeout;

    logic [NM-1:0] w_pick;
    logic [LW-1:0] w_pick_idx;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_dat;
    logic [SW-1:0] w_sel;
    logic [2:0]    w_cti;
    logic [1:0]    w_bte;
    logic          w_we;
    logic          w_gcyc;
    logic          w_gstb;
    logic          w_bus;
    logic          w_resp;
    logic          w_abort;

    wb_rr_pick #(
        .NM (NM),
        .LW (LW)
    ) u_pick (
        .i_req  (wbm_cyc_i),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    // Grant is one-hot, so a plain select per master is enough.
    always_comb begin
        w_adr      = '0;
        w_dat      = '0;
        w_sel      = '0;
        w_cti      = '0;
        w_bte      = '0;
        w_we       = 1'b0;
        w_gcyc     = 1'b0;
        w_gstb     = 1'b0;
        w_pick_idx = '0;
        for (int i = 0; i < NM; i++) begin
            if (r_grant[i]) begin
                w_adr  = wbm_adr_i[i*AW +: AW];
                w_dat  = wbm_dat_i[i*DW +: DW];
                w_sel  = wbm_sel_i[i*SW +: SW];
                w_cti  = wbm_cti_i[i*3 +: 3];
                w_bte  = wbm_bte_i[i*2 +: 2];
                w_we   = wbm_we_i[i];
                w_gcyc = wbm_cyc_i[i];
                w_gstb = wbm_stb_i[i];
            end
            if (w_pick[i]) begin
                w_pick_idx = LW'(i);
            end
        end
    end

    assign w_bus  = (r_state == BUS);
    assign w_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    assign wbs_adr_o = w_adr;
    assign wbs_dat_o = w_dat;
    assign wbs_sel_o = w_sel;
    assign wbs_we_o  = w_we;
    assign wbs_cti_o = w_cti;
    assign wbs_bte_o = w_bte;
    assign wbs_cyc_o = w_bus & w_gcyc;
    assign wbs_stb_o = w_bus & w_gstb;

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = w_bus ? (r_grant & {NM{wbs_ack_i}}) : '0;
    assign wbm_rty_o = w_bus ? (r_grant & {NM{wbs_rty_i}}) : '0;
    assign wbm_err_o = w_bus                ? (r_grant & {NM{wbs_err_i}}) :
                       (r_state == ABORT)   ? r_grant : '0;

    // Any response in the limit cycle wins over the abort.
    assign w_abort = w_gcyc & wbs_stb_o & ~w_resp & (r_wdog == WDOG_LIMIT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !wbs_stb_o || w_resp) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_last    <= LW'(NM - 1);
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|wbm_cyc_i) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick_idx;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    if (!w_gcyc) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end else if (w_abort) begin
                        r_timeout <= 1'b1;
                        r_state   <= ABORT;
                    end
                end
                ABORT: begin
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!w_gcyc) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

    a_grant_onehot: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        $onehot0(r_grant));
    a_cyc_granted: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        wbs_cyc_o |-> (r_grant != '0));

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed master traffic, a small
// slave with programmable ack latency, and a monitor that pops expected
// responses and grants from queues filled by the stimulus.
module tb_wb_mem_arbiter;
    import wb_arb_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } resp_t;

    typedef struct packed {
        logic [NM-1:0] g;
        int            gap;
    } gexp_t;

    logic               clk;
    logic               rst;
    logic [NM*AW-1:0]   wbm_adr_i;
    logic [NM*DW-1:0]   wbm_dat_i;
    logic [NM*DW/8-1:0] wbm_sel_i;
    logic [NM-1:0]      wbm_we_i;
    logic [NM-1:0]      wbm_cyc_i;
    logic [NM-1:0]      wbm_stb_i;
    logic [NM*3-1:0]    wbm_cti_i;
    logic [NM*2-1:0]    wbm_bte_i;
    logic [DW-1:0]      wbm_dat_o;
    logic [NM-1:0]      wbm_ack_o;
    logic [NM-1:0]      wbm_err_o;
    logic [NM-1:0]      wbm_rty_o;
    logic [AW-1:0]      wbs_adr_o;
    logic [DW-1:0]      wbs_dat_o;
    logic [DW/8-1:0]    wbs_sel_o;
    logic               wbs_we_o;
    logic               wbs_cyc_o;
    logic               wbs_stb_o;
    logic [2:0]         wbs_cti_o;
    logic [1:0]         wbs_bte_o;
    logic [DW-1:0]      s_dat;
    logic               s_ack;
    logic [NM-1:0]      grant_o;
    logic               timeout_o;

    logic [AW-1:0] m_adr [NM];
    logic          m_cyc [NM];
    logic          m_stb [NM];
    logic [2:0]    m_cti [NM];

    resp_t exp_q [NM][$];
    gexp_t exp_g [$];

    int checks  = 0;
    int errors  = 0;
    int lat     = 1;
    bit never   = 1'b0;
    int tpulses = 0;

    function automatic logic [31:0] mdat(input int m);
        return {8'(m + 1), 24'h00_0000};
    endfunction

    function automatic logic [3:0] msel(input int m);
        return 4'(1 << m);
    endfunction

    // Slave returns adr ^ dat ^ {sel, cti}, so the routed address, data,
    // selects and cycle type are all visible in the read data.
    function automatic logic [31:0] beat_data(input int m, input logic [31:0] adr, input logic [2:0] cti);
        return adr ^ mdat(m) ^ {msel(m), 25'b0, cti};
    endfunction

    function automatic logic bit_of(input logic [NM-1:0] v, input int m);
        logic [NM-1:0] s;
        s = v >> m;
        return s[0];
    endfunction

    for (genvar g = 0; g < NM; g++) begin : g_m
        assign wbm_adr_i[g*AW +: AW] = m_adr[g];
        assign wbm_dat_i[g*DW +: DW] = mdat(g);
        assign wbm_sel_i[g*4 +: 4]   = msel(g);
        assign wbm_cti_i[g*3 +: 3]   = m_cti[g];
        assign wbm_bte_i[g*2 +: 2]   = 2'b00;
        assign wbm_we_i[g]           = 1'b0;
        assign wbm_cyc_i[g]          = m_cyc[g];
        assign wbm_stb_i[g]          = m_stb[g];
    end

    wb_mem_arbiter #(
        .NM      (NM),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_cti_i (wbm_cti_i),
        .wbm_bte_i (wbm_bte_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (s_dat),
        .wbs_ack_i (s_ack),
        .wbs_err_i (1'b0),
        .wbs_rty_i (1'b0),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp_push(input int m, input logic e, input logic [31:0] d);
        resp_t r;
        r.err = e;
        r.dat = d;
        exp_q[m].push_back(r);
    endtask

    task automatic gnt_push(input int m, input int gap);
        gexp_t x;
        x.g   = NM'(1 << m);
        x.gap = gap;
        exp_g.push_back(x);
    endtask

    // Slave: acks on the lat-th consecutive strobe cycle.
    int s_cnt = 0;
    initial begin
        s_ack = 1'b0;
        s_dat = '0;
        forever begin
            @(posedge clk);
            #2;
            if (wbs_cyc_o && wbs_stb_o) begin
                s_ack = !never && (s_cnt == lat - 1);
                s_dat = wbs_adr_o ^ wbs_dat_o ^ {wbs_sel_o, 25'b0, wbs_cti_o};
                s_cnt = s_ack ? 0 : s_cnt + 1;
            end else begin
                s_ack = 1'b0;
                s_cnt = 0;
            end
        end
    end

    // Monitor: responses, grant order/gaps, timeout pulses.
    initial begin
        logic [NM-1:0] prev_g;
        int            zrun;
        resp_t         r;
        gexp_t         x;
        prev_g = '0;
        zrun   = 0;
        forever begin
            @(negedge clk);
            for (int m = 0; m < NM; m++) begin
                if (bit_of(wbm_ack_o, m) || bit_of(wbm_err_o, m)) begin
                    if (exp_q[m].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp master=%0d ack=%0b err=%0b required=none t=%0t",
                                 m, bit_of(wbm_ack_o, m), bit_of(wbm_err_o, m), $time);
                    end else begin
                        r = exp_q[m].pop_front();
                        chk($sformatf("resp_err_m%0d", m), 32'(bit_of(wbm_err_o, m)), 32'(r.err));
                        chk($sformatf("resp_ack_m%0d", m), 32'(bit_of(wbm_ack_o, m)), 32'(!r.err));
                        if (!r.err) chk($sformatf("resp_dat_m%0d", m), wbm_dat_o, r.dat);
                    end
                end
            end
            if (grant_o == '0) begin
                zrun++;
            end else begin
                if (prev_g == '0) begin
                    if (exp_g.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant actual=0x%0h required=none t=%0t", grant_o, $time);
                    end else begin
                        x = exp_g.pop_front();
                        chk("grant_order", 32'(grant_o), 32'(x.g));
                        if (x.gap >= 0) chk("grant_gap", 32'(zrun), 32'(x.gap));
                    end
                end
                zrun = 0;
            end
            prev_g = grant_o;
            if (timeout_o) tpulses++;
        end
    end

    task automatic m_access(input int m, input logic [31:0] adr, input int nbeats, input bit chk_lat);
        bit          seen;
        logic [2:0]  cti;
        logic [31:0] a;
        for (int b = 0; b < nbeats; b++) begin
            a   = adr + 32'(4 * b);
            cti = (nbeats == 1) ? CLASSIC : ((b == nbeats - 1) ? EOB : INCR);
            exp_push(m, 1'b0, beat_data(m, a, cti));
            @(posedge clk);
            #1;
            m_adr[m] = a;
            m_cti[m] = cti;
            m_cyc[m] = 1'b1;
            m_stb[m] = 1'b1;
            if (chk_lat && b == 0) begin
                @(negedge clk);
                chk("lat_idle_grant", 32'(grant_o), 32'h0);
            end
            seen = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (chk_lat && b == 0 && c == 0) chk("lat_grant", 32'(grant_o), 32'(1) << m);
                if (bit_of(wbm_ack_o, m) || bit_of(wbm_err_o, m)) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL resp_wait master=%0d actual=no_response required=response", m);
            end
        end
        @(posedge clk);
        #1;
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        if (chk_lat) begin
            @(negedge clk);
            chk("hold_grant_after_drop", 32'(grant_o), 32'(1) << m);
            @(negedge clk);
            chk("grant_clear", 32'(grant_o), 32'h0);
        end
        @(posedge clk);
    endtask

    initial begin
        bit seen;
        int stb_n;
        for (int m = 0; m < NM; m++) begin
            m_adr[m] = '0;
            m_cti[m] = CLASSIC;
            m_cyc[m] = 1'b0;
            m_stb[m] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_cyc", 32'(wbs_cyc_o), 32'h0);
        chk("rst_stb", 32'(wbs_stb_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        chk("rst_ack", 32'(wbm_ack_o), 32'h0);
        chk("rst_err", 32'(wbm_err_o), 32'h0);

        // Contention: all three request at once after reset.
        lat = 1;
        gnt_push(0, -1);
        gnt_push(1, 1);
        gnt_push(2, 1);
        gnt_push(0, 1);
        fork
            begin
                m_access(0, 32'h0000_0010, 1, 1'b0);
                m_access(0, 32'h0000_0014, 1, 1'b0);
            end
            m_access(1, 32'h0000_0020, 1, 1'b0);
            m_access(2, 32'h0000_0030, 1, 1'b0);
        join
        repeat (2) @(posedge clk);

        // Single master read with latency checks.
        lat = 3;
        gnt_push(1, -1);
        m_access(1, 32'h0000_0100, 1, 1'b1);

        // Timeout: slave never answers.
        never = 1'b1;
        gnt_push(1, -1);
        exp_push(1, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        m_adr[1] = 32'h0000_0300;
        m_cti[1] = CLASSIC;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        seen  = 1'b0;
        stb_n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (wbm_err_o[1]) begin
                seen = 1'b1;
                break;
            end
            if (wbs_stb_o) stb_n++;
        end
        chk("to_err_seen", 32'(seen), 32'h1);
        chk("to_stb_cycles", 32'(stb_n), 32'd8);
        chk("to_pulse", 32'(timeout_o), 32'h1);
        chk("to_abort_cyc", 32'(wbs_cyc_o), 32'h0);
        @(negedge clk);
        chk("to_pulse_end", 32'(timeout_o), 32'h0);
        chk("drain_cyc", 32'(wbs_cyc_o), 32'h0);
        chk("drain_err", 32'(wbm_err_o), 32'h0);
        chk("drain_grant", 32'(grant_o), 32'h2);
        @(negedge clk);
        chk("drain_cyc2", 32'(wbs_cyc_o), 32'h0);
        @(posedge clk);
        #1;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        @(negedge clk);
        chk("drain_grant_held", 32'(grant_o), 32'h2);
        @(negedge clk);
        chk("drain_to_idle", 32'(grant_o), 32'h0);
        never = 1'b0;
        @(posedge clk);

        // Ack on the 8th strobe cycle beats the watchdog.
        lat = 8;
        gnt_push(1, -1);
        m_access(1, 32'h0000_0104, 1, 1'b0);

        // Burst lock: master 2 waits for all four beats of master 0.
        lat = 2;
        gnt_push(0, -1);
        gnt_push(2, -1);
        fork
            m_access(0, 32'h0000_0200, 4, 1'b0);
            begin
                repeat (2) @(posedge clk);
                m_access(2, 32'h0000_0600, 1, 1'b0);
            end
        join
        repeat (2) @(posedge clk);

        // Reset in the middle of a burst.
        lat = 2;
        gnt_push(0, -1);
        gnt_push(0, -1);
        exp_push(0, 1'b0, beat_data(0, 32'h0000_0400, INCR));
        @(posedge clk);
        #1;
        m_adr[0] = 32'h0000_0400;
        m_cti[0] = INCR;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_adr[2] = 32'h0000_0500;
        m_cti[2] = CLASSIC;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (wbm_ack_o[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rb_beat1_seen", 32'(seen), 32'h1);
        @(posedge clk);
        #1;
        m_adr[0] = 32'h0000_0404;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rb_grant", 32'(grant_o), 32'h0);
        chk("rb_cyc", 32'(wbs_cyc_o), 32'h0);
        chk("rb_ack", 32'(wbm_ack_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rb_first_grant", 32'(grant_o), 32'h1);
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rb_idle", 32'(grant_o), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        for (int m = 0; m < NM; m++) begin
            chk($sformatf("pending_resp_m%0d", m), 32'(exp_q[m].size()), 32'h0);
        end
        chk("pending_grants", 32'(exp_g.size()), 32'h0);
        chk("timeout_pulses", 32'(tpulses), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
